// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU stage: opcodes, FSM states and
// the default datapath width.
package alu_pkg;

   localparam int DEF_WIDTH = 32;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_NOR  = 3'b011;
   localparam logic [2:0] OP_LESS = 3'b100;
   localparam logic [2:0] OP_ADD  = 3'b101;
   localparam logic [2:0] OP_SUB  = 3'b110;
   localparam logic [2:0] OP_MOD  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_seq_32_if.sv
// Request/response bundle between an issuing master and the ALU stage.
interface alu_seq_32_if #(parameter int WIDTH = 32);

   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             overflow;
   logic             div_zero;
   logic             busy;
   logic             done;

   modport master (
      output start, op, a, b,
      input  result, zero, overflow, div_zero, busy, done
   );

   modport slave (
      input  start, op, a, b,
      output result, zero, overflow, div_zero, busy, done
   );

endinterface

// File: rtl/alu_mod_seq.sv
// Unsigned remainder by repeated subtraction: one compare-subtract per step
// until the running remainder drops below the divisor.
module alu_mod_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_step,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_finished
);

   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_breg;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rem  <= '0;
         r_breg <= '0;
      end else if (i_load) begin
         r_rem  <= i_a;
         r_breg <= i_b;
      end else if (i_step && !o_finished) begin
         r_rem  <= r_rem - r_breg;
      end
   end

   assign o_finished = (r_rem < r_breg);
   assign o_rem      = r_rem;

endmodule

// File: rtl/alu_seq_32.sv
// Registered ALU execution stage: single-cycle logic/arith ops plus a
// multi-cycle unsigned MOD, results held until the next accepted start.
module alu_seq_32
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input logic         clk,
   input logic         reset,
   alu_seq_32_if.slave bus
);

   // state  | meaning
   // IDLE   | waiting for start, last result held
   // CALC   | MOD in progress, one subtract per cycle
   // DONE   | result valid, done pulse; start here issues back-to-back
   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_ovf;
   logic             r_dz;

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic             w_ovf_add;
   logic             w_ovf_sub;
   logic [WIDTH-1:0] w_op_res;
   logic             w_op_ovf;
   logic             w_op_dz;

   logic             w_load;
   logic [WIDTH-1:0] w_res_nxt;
   logic             w_ovf_nxt;
   logic             w_dz_nxt;
   logic             w_mod_load;
   logic [WIDTH-1:0] w_rem;
   logic             w_finished;

   assign w_sum     = bus.a + bus.b;
   assign w_diff    = bus.a - bus.b;
   assign w_ovf_add = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (w_sum[WIDTH-1]  != bus.a[WIDTH-1]);
   assign w_ovf_sub = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (w_diff[WIDTH-1] != bus.a[WIDTH-1]);

   always_comb begin
      w_op_res = '0;
      w_op_ovf = 1'b0;
      w_op_dz  = 1'b0;
      case (bus.op)
         OP_AND:  w_op_res = bus.a & bus.b;
         OP_OR:   w_op_res = bus.a | bus.b;
         OP_XOR:  w_op_res = bus.a ^ bus.b;
         OP_NOR:  w_op_res = ~(bus.a | bus.b);
         OP_LESS: w_op_res = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1] ^ w_ovf_sub};
         OP_ADD: begin
            w_op_res = w_sum;
            w_op_ovf = w_ovf_add;
         end
         OP_SUB: begin
            w_op_res = w_diff;
            w_op_ovf = w_ovf_sub;
         end
         // only reached single-cycle when b == 0; b != 0 goes through CALC
         OP_MOD: begin
            w_op_res = bus.a;
            w_op_dz  = 1'b1;
         end
         default: w_op_res = '0;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_res_nxt   = '0;
      w_ovf_nxt   = 1'b0;
      w_dz_nxt    = 1'b0;
      w_mod_load  = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               if (bus.op == OP_MOD && bus.b != '0) begin
                  w_mod_load  = 1'b1;
                  w_state_nxt = S_CALC;
               end else begin
                  w_load      = 1'b1;
                  w_res_nxt   = w_op_res;
                  w_ovf_nxt   = w_op_ovf;
                  w_dz_nxt    = w_op_dz;
                  w_state_nxt = S_DONE;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_CALC: begin
            if (w_finished) begin
               w_load      = 1'b1;
               w_res_nxt   = w_rem;
               w_state_nxt = S_DONE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_result <= '0;
         r_zero   <= 1'b1;
         r_ovf    <= 1'b0;
         r_dz     <= 1'b0;
      end else if (w_load) begin
         r_result <= w_res_nxt;
         r_zero   <= (w_res_nxt == '0);
         r_ovf    <= w_ovf_nxt;
         r_dz     <= w_dz_nxt;
      end
   end

   alu_mod_seq #(.WIDTH(WIDTH)) u_mod (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_mod_load),
      .i_step     (r_state == S_CALC),
      .i_a        (bus.a),
      .i_b        (bus.b),
      .o_rem      (w_rem),
      .o_finished (w_finished)
   );

   assign bus.result   = r_result;
   assign bus.zero     = r_zero;
   assign bus.overflow = r_ovf;
   assign bus.div_zero = r_dz;
   assign bus.busy     = (r_state != S_IDLE);
   assign bus.done     = (r_state == S_DONE);

endmodule

// File: tb/tb_alu_seq_32.sv
// Directed and randomized checks of alu_seq_32 against an arithmetic
// reference model of each opcode, its flags and its latency.
module tb_alu_seq_32;
   import alu_pkg::*;

   localparam int     W    = 32;
   localparam longint MAXS = 64'sd2147483647;
   localparam longint MINS = -64'sd2147483648;

   logic clk = 1'b0;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   alu_seq_32_if #(.WIDTH(W)) bus();

   alu_seq_32 #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ovf, output logic dz,
                                  output int lat);
      longint sa, sb, s;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      s   = 0;
      r   = '0;
      ovf = 1'b0;
      dz  = 1'b0;
      lat = 1;
      case (op)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: r = a ^ b;
         3'd3: r = ~(a | b);
         3'd4: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd5: begin
            s = sa + sb;
            r = s[31:0];
            ovf = (s > MAXS) || (s < MINS);
         end
         3'd6: begin
            s = sa - sb;
            r = s[31:0];
            ovf = (s > MAXS) || (s < MINS);
         end
         default: begin
            if (b == 0) begin
               r  = a;
               dz = 1'b1;
            end else begin
               r   = a % b;
               lat = int'(a / b) + 2;
            end
         end
      endcase
   endfunction

   // Called mid-cycle; returns mid-cycle in the DONE cycle (or after timeout).
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit inject, input string tag);
      logic [31:0] er;
      logic        eovf, edz;
      int          elat, lat, busy_cnt;
      ref_op(op, a, b, er, eovf, edz, elat);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.op    = 3'($urandom);
      bus.a     = $urandom;
      bus.b     = $urandom;
      lat      = 1;
      busy_cnt = 0;
      while (!bus.done && lat < 200) begin
         if (bus.busy) busy_cnt++;
         if (inject && lat == 2) begin
            bus.start = 1'b1;
            bus.op    = OP_AND;
         end
         @(posedge clk); #1;
         bus.start = 1'b0;
         lat++;
      end
      if (bus.busy) busy_cnt++;
      chk({tag, " latency"},  lat,          elat);
      chk({tag, " busy"},     busy_cnt,     elat);
      chk({tag, " result"},   bus.result,   er);
      chk({tag, " zero"},     bus.zero,     (er == 0));
      chk({tag, " overflow"}, bus.overflow, eovf);
      chk({tag, " div_zero"}, bus.div_zero, edz);
   endtask

   task automatic idle_chk(input string tag);
      @(posedge clk); #1;
      chk({tag, " idle busy"}, bus.busy, 1'b0);
      chk({tag, " idle done"}, bus.done, 1'b0);
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      bit          seen;

      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = '0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst result",   bus.result,   32'd0);
      chk("rst zero",     bus.zero,     1'b1);
      chk("rst overflow", bus.overflow, 1'b0);
      chk("rst div_zero", bus.div_zero, 1'b0);
      chk("rst busy",     bus.busy,     1'b0);
      chk("rst done",     bus.done,     1'b0);
      reset = 1'b0;

      run_op(OP_NOR, 32'hF0F00000, 32'h0F0F00FF, 1'b0, "nor");
      idle_chk("nor");
      run_op(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, "add_ovf");
      idle_chk("add_ovf");
      run_op(OP_SUB, 32'h00001234, 32'h00001234, 1'b0, "sub_zero");
      run_op(OP_LESS, 32'hFFFFFFFF, 32'h00000001, 1'b0, "less_b2b");
      idle_chk("less_b2b");
      run_op(OP_MOD, 32'd17, 32'd5, 1'b1, "mod17_5");
      idle_chk("mod17_5");
      run_op(OP_MOD, 32'd20, 32'd5, 1'b0, "mod20_5");
      run_op(OP_MOD, 32'd9, 32'd0, 1'b0, "mod_by0");
      idle_chk("mod_by0");
      run_op(OP_MOD, 32'd3, 32'd7, 1'b0, "mod_small");
      idle_chk("mod_small");

      // reset asserted during the third CALC cycle of a long MOD
      bus.start = 1'b1;
      bus.op    = OP_MOD;
      bus.a     = 32'd1000;
      bus.b     = 32'd1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midrst busy",   bus.busy,   1'b0);
      chk("midrst done",   bus.done,   1'b0);
      chk("midrst result", bus.result, 32'd0);
      chk("midrst zero",   bus.zero,   1'b1);
      seen = 1'b0;
      repeat (1100) begin
         @(posedge clk); #1;
         if (bus.done) seen = 1'b1;
      end
      chk("midrst no done", seen, 1'b0);

      for (int i = 0; i < 300; i++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 9))
            0: a = 32'h80000000;
            1: a = 32'h7FFFFFFF;
            2: b = a;
            3: b = 32'h80000000;
            default: ;
         endcase
         if (op == OP_MOD) begin
            if ($urandom_range(0, 3) == 0) b = 32'd0;
            else b = (a >> $urandom_range(1, 5)) + 32'($urandom_range(1, 100));
         end
         run_op(op, a, b, 1'b0, $sformatf("rnd%0d op%0d", i, op));
         if ($urandom_range(0, 1) == 1) idle_chk($sformatf("rnd%0d", i));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq_32.md
Name: alu_seq_32

Overview:
- Registered 32-bit ALU execution stage. It directly consumes the bitwise logic-unit results (AND/OR/XOR/NOR) and the adder/subtractor outputs.
- Adds a multi-cycle unsigned MOD operation built from repeated subtraction.
- Captures operands and opcode on a start pulse and returns a registered result with a done pulse.
- Feeds the register-file write-back path.

Parameters:
- WIDTH, 32, datapath width in bits. All operand and result widths follow WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; all state cleared on the clk edge where reset=1.
- start  input  1  one-cycle request; captures a, b and op. Accepted only in IDLE or DONE.
- op  input  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 LESS (signed), 101 ADD, 110 SUB, 111 MOD (unsigned).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- result  output  WIDTH  registered result; held until the next accepted start.
- zero  output  1  registered; equals (result == 0).
- overflow  output  1  signed overflow for ADD/SUB; 0 for all other ops.
- div_zero  output  1  set when MOD is issued with b == 0; 0 otherwise.
- busy  output  1  high when state is not IDLE.
- done  output  1  one-cycle pulse when result is valid.

Behaviour:
- Reset: state=IDLE; result=0, zero=1, overflow=0, div_zero=0, busy=0, done=0; remainder and b registers cleared.
- Reset has priority over everything, including mid-MOD. No partial result is retained.
- States: IDLE, CALC, DONE.
- Ops 000–110, from IDLE or DONE with start=1:
  - result, zero, overflow are loaded at that edge; div_zero=0; next state DONE.
  - Latency 1: done=1 in the following cycle.
- LESS: result = {WIDTH-1 zeros, (a-b)[MSB] XOR ovf_sub}.
- ADD/SUB: wrap modulo 2^WIDTH.
  - overflow is set when both operands have the same sign (ADD), or b has the opposite sign to a (SUB), and the result sign differs from a.
- MOD with b != 0:
  - Start edge: rem<=a, breg<=b, next state CALC.
  - Each CALC edge: if rem >= breg then rem<=rem-breg; else result<=rem, next state DONE.
  - CALC lasts floor(a/b)+1 cycles. done rises floor(a/b)+2 cycles after the start edge.
- MOD with b == 0: result<=a, div_zero<=1, next state DONE; latency 1.
- DONE: done=1 for exactly one cycle.
  - If start=1 in DONE, the new operation is accepted at that edge (back-to-back issue allowed).
  - Otherwise the next state is IDLE.
- start while in CALC is ignored. a, b and op changes during busy are ignored.
- result and the flags update only on acceptance or MOD completion. They hold through IDLE.
- zero is always consistent with the registered result, including after MOD.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_AND … OP_MOD (3 bits).
  - state encoding constants S_IDLE, S_CALC, S_DONE (2 bits).
  - WIDTH default.
- One natural sub-module, alu_mod_seq: the remainder/divisor registers and the compare-subtract step. Interface: load, a, b, step, rem, finished.
- The top level owns the FSM, the op mux and the flags.

Test Plan:
- NOR: a=0xF0F00000, b=0x0F0F00FF, op=011, start pulse → next cycle done=1, result=0x0000FF00, zero=0, overflow=0, busy=0 after DONE.
- ADD overflow: a=0x7FFFFFFF, b=0x00000001, op=101 → result=0x80000000, overflow=1, zero=0, latency 1.
- SUB zero / LESS:
  - a=b=0x00001234, op=110 → result=0, zero=1, overflow=0.
  - Then back-to-back start in DONE with a=0xFFFFFFFF, b=1, op=100 → result=1 on the next done.
- MOD: a=17, b=5, op=111 →
  - busy=1 for 5 cycles, done in the 5th cycle after the start edge, result=2, div_zero=0.
  - A start with op=000 pulsed during CALC is ignored (result stays 2).
- MOD by zero: a=9, b=0, op=111 → done after 1 cycle, result=9, div_zero=1.
- Reset mid-MOD: a=1000, b=1, op=111, reset=1 on cycle 3 of CALC →
  - next cycle: state IDLE, busy=0, done=0, result=0, zero=1; no done pulse follows.
